// File: rtl/arc_mem_pkg.sv
// Shared definitions for the main_memory port arbiter.
// Contents:
//   state_e        access sequencer states (IDLE, ACCESS, RESP)
//   PORT_F/PORT_D  requester identifiers used for grant and last-grant tracking
//   DEF_ADDR_W/DEF_DATA_W  default bus widths
//   is_misaligned  word-alignment test on the two address LSBs
package arc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a last-grant register.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (last grant resets to F)
//   req_f_i      fetch port request
//   req_d_i      data port request
//   update_i     commit the current grant as the new last grant
//   valid_o      at least one request present
//   gnt_o        granted port id (PORT_F / PORT_D), meaningful when valid_o=1
module rr_arbiter2
  import arc_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_f_i,
  input  logic req_d_i,
  input  logic update_i,
  output logic valid_o,
  output logic gnt_o
);

  logic last_grant_q;
  logic last_grant_d;
  logic gnt_s;

  // Grant selection: a lone request wins outright; a contest goes to the port that did not win last.
  always_comb begin
    gnt_s = PORT_F;
    case ({req_d_i, req_f_i})
      2'b01:   gnt_s = PORT_F;
      2'b10:   gnt_s = PORT_D;
      2'b11:   gnt_s = (last_grant_q == PORT_F) ? PORT_D : PORT_F;
      default: gnt_s = PORT_F;
    endcase
  end

  // Last-grant next state: only moves when the sequencer actually takes a grant.
  always_comb begin
    if (update_i) begin
      last_grant_d = gnt_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_F;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign valid_o = req_f_i | req_d_i;
  assign gnt_o   = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main_memory port between instruction fetch (F) and the
// load/store datapath (D). Each access runs IDLE -> ACCESS -> RESP; misaligned
// requests (when ALIGN_CHECK=1) skip ACCESS and are answered with err.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   f_req/f_addr             fetch request (read-only), held until f_ack
//   f_ack/f_err/f_rdata      fetch completion pulse, misalign flag, read data
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_err/d_rdata      data completion pulse, misalign flag, load data
//   mem_addr/mem_wdata/mem_rd/mem_wr  main_memory controls (registered)
//   mem_rdata                main_memory read data (valid one cycle after mem_rd)
//   busy                     high whenever the sequencer is not in IDLE
module mem_port_arbiter
  import arc_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              f_err_q, f_err_d;
  logic              d_err_q, d_err_d;
  logic              busy_q, busy_d;

  logic              arb_valid_s;
  logic              arb_gnt_s;
  logic              arb_update_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;
  logic              sel_misaligned_s;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst),
    .req_f_i  (f_req),
    .req_d_i  (d_req),
    .update_i (arb_update_s),
    .valid_o  (arb_valid_s),
    .gnt_o    (arb_gnt_s)
  );

  // Request mux: fetch never writes, so it presents we=0 and zero write data.
  always_comb begin
    if (arb_gnt_s == PORT_D) begin
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
      sel_we_s    = d_we;
    end else begin
      sel_addr_s  = f_addr;
      sel_wdata_s = {DATA_W{1'b0}};
      sel_we_s    = 1'b0;
    end
    sel_misaligned_s = ALIGN_CHECK && is_misaligned(sel_addr_s[1:0]);
  end

  // Sequencer next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    f_err_d      = 1'b0;
    d_err_d      = 1'b0;
    arb_update_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          arb_update_s = 1'b1;
          gnt_d        = arb_gnt_s;
          mem_addr_d   = sel_addr_s;
          mem_wdata_d  = sel_wdata_s;
          if (sel_misaligned_s) begin
            // Rejected without touching memory: answer straight away.
            state_d = RESP;
            f_ack_d = (arb_gnt_s == PORT_F);
            d_ack_d = (arb_gnt_s == PORT_D);
            f_err_d = (arb_gnt_s == PORT_F);
            d_err_d = (arb_gnt_s == PORT_D);
          end else begin
            state_d  = ACCESS;
            mem_rd_d = ~sel_we_s;
            mem_wr_d = sel_we_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Memory captures rd/wr at the end of this cycle; its data appears in RESP.
        state_d = RESP;
        f_ack_d = (gnt_q == PORT_F);
        d_ack_d = (gnt_q == PORT_D);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= PORT_F;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_err_q     <= f_err_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_err     = f_err_q;
  assign d_err     = d_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;

  // Read data passes straight through from memory to whichever port is being acked.
  assign f_rdata = f_ack_q ? mem_rdata : {DATA_W{1'b0}};
  assign d_rdata = d_ack_q ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = 32'h0;
  logic        f_ack, f_err;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic        ref_last;
  logic [31:0] ref_mem [0:1023];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0) return 32'hC200_2001;
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  // Stand-in for main_memory: 4 KiB, registered read, write on edge with wr=1.
  logic [31:0] wmem [0:1023];
  bit          written [0:1023];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rdata <= 32'h0;
    end else begin
      if (mem_wr) begin
        wmem[mem_addr[11:2]]    <= mem_wdata;
        written[mem_addr[11:2]] <= 1'b1;
      end
      if (mem_rd) mem_rdata <= written[mem_addr[11:2]] ? wmem[mem_addr[11:2]] : init_word(32'(mem_addr[11:2]));
    end
  end

  // Protocol monitor: exclusive rd/wr and exclusive acks.
  always @(negedge clk) begin
    if (mem_rd && mem_wr) viol <= viol + 1;
    if (f_ack && d_ack) viol <= viol + 1;
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({f_ack, f_err, d_ack, d_err, mem_rd, mem_wr, busy} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0", {f_ack, f_err, d_ack, d_err, mem_rd, mem_wr, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_bus: addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    rst = 1'b1;
    ref_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    f_addr = 32'h0; f_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, busy, f_ack} !== 4'b1010) begin
      failures++; $display("FAIL fetch_access: rd/wr/busy/ack %b expected 1010", {mem_rd, mem_wr, busy, f_ack});
    end
    @(negedge clk);
    checks++;
    if ({f_ack, f_err, d_ack} !== 3'b100 || f_rdata !== 32'hC200_2001) begin
      failures++; $display("FAIL fetch_resp: ack/err %b rdata %h expected 100 c2002001", {f_ack, f_err, d_ack}, f_rdata);
    end
    f_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_ack, busy} !== 2'b00) begin
      failures++; $display("FAIL fetch_end: ack/busy %b expected 00", {f_ack, busy});
    end
    ref_last = 1'b0;
  endtask

  task automatic test_store_load();
    d_we = 1'b1; d_addr = 32'd2048; d_wdata = 32'h0000_0014; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr} !== 2'b01 || mem_addr !== 32'd2048 || mem_wdata !== 32'h14) begin
      failures++; $display("FAIL store_access: rd/wr %b addr %0d wdata %h expected 01 2048 14", {mem_rd, mem_wr}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({d_ack, d_err, f_ack} !== 3'b100) begin
      failures++; $display("FAIL store_ack: %b expected 100", {d_ack, d_err, f_ack});
    end
    d_req = 1'b0;
    ref_mem[512] = 32'h14;
    @(negedge clk);
    d_we = 1'b0; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== ref_mem[512]) begin
      failures++; $display("FAIL load_back: ack %b rdata %h expected 1 %h", d_ack, d_rdata, ref_mem[512]);
    end
    d_req = 1'b0;
    @(negedge clk);
    ref_last = 1'b1;
  endtask

  task automatic test_conflict();
    int fk, dk, single_k;
    for (int r = 0; r < 2; r++) begin
      f_addr = 32'h8; d_we = 1'b0; d_addr = 32'h10;
      f_req = 1'b1; d_req = 1'b1;
      fk = 0; dk = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (d_ack && dk == 0) begin
          dk = k; d_req = 1'b0;
          checks++;
          if (d_rdata !== ref_mem[4] || f_rdata !== 32'h0) begin
            failures++; $display("FAIL conflict_d_rdata: %h/%h expected %h/0", d_rdata, f_rdata, ref_mem[4]);
          end
        end
        if (f_ack && fk == 0) begin
          fk = k; f_req = 1'b0;
          checks++;
          if (f_rdata !== ref_mem[2] || d_rdata !== 32'h0) begin
            failures++; $display("FAIL conflict_f_rdata: %h/%h expected %h/0", f_rdata, d_rdata, ref_mem[2]);
          end
        end
      end
      f_req = 1'b0; d_req = 1'b0;
      checks++;
      // With last grant F the contest goes to D, otherwise to F; loser 3 cycles later.
      if (ref_last == 1'b0) begin
        if (dk !== 2 || fk !== 5) begin
          failures++; $display("FAIL conflict_order_d_first: d_ack@%0d f_ack@%0d expected 2 5", dk, fk);
        end
        ref_last = 1'b0;
      end else begin
        if (fk !== 2 || dk !== 5) begin
          failures++; $display("FAIL conflict_order_f_first: f_ack@%0d d_ack@%0d expected 2 5", fk, dk);
        end
        ref_last = 1'b1;
      end
      if (r == 0) begin
        // Lone D access so the next contest should go to F.
        d_addr = 32'h20; d_req = 1'b1;
        single_k = 0;
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          if (d_ack && single_k == 0) begin single_k = k; d_req = 1'b0; end
        end
        d_req = 1'b0;
        ref_last = 1'b1;
        checks++;
        if (single_k !== 2) begin
          failures++; $display("FAIL conflict_single_d: ack@%0d expected 2", single_k);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    int wr_cnt, ak;
    logic er;
    d_we = 1'b1; d_addr = 32'd2050; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    wr_cnt = 0; ak = 0; er = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (mem_wr || mem_rd) wr_cnt++;
      if (d_ack && ak == 0) begin ak = k; er = d_err; d_req = 1'b0; end
    end
    checks++;
    if (ak !== 1 || er !== 1'b1 || wr_cnt !== 0) begin
      failures++; $display("FAIL misaligned: ack@%0d err %b memops %0d expected 1 1 0", ak, er, wr_cnt);
    end
    ref_last = 1'b1;
    d_we = 1'b0; d_addr = 32'd2048; d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== ref_mem[512]) begin
      failures++; $display("FAIL misaligned_nowrite: ack %b data %h expected 1 %h", d_ack, d_rdata, ref_mem[512]);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acks;
    d_we = 1'b1; d_addr = 32'd2056; d_wdata = 32'hA5A5_5A5A; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wr, busy} !== 2'b11) begin
      failures++; $display("FAIL rstmid_access: wr/busy %b expected 11", {mem_wr, busy});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_wr, busy, d_ack, f_ack} !== 4'b0) begin
      failures++; $display("FAIL rstmid_async: wr/busy/acks %b expected 0000", {mem_wr, busy, d_ack, f_ack});
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_last = 1'b0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (d_ack || f_ack || busy) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++; $display("FAIL rstmid_noack: %0d active cycles expected 0", acks);
    end
    d_we = 1'b0; d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== ref_mem[514]) begin
      failures++; $display("FAIL rstmid_nowrite: ack %b data %h expected 1 %h", d_ack, d_rdata, ref_mem[514]);
    end
    d_req = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int idx [4];
    int n;
    logic f_seen;
    for (int i = 0; i < 4; i++) idx[i] = $urandom_range(0, 1023);
    n = 0; f_seen = 1'b0;
    d_we = 1'b0; d_addr = 32'(idx[0]) << 2; d_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (f_ack) f_seen = 1'b1;
      if (d_ack && n < 4) begin
        checks++;
        if (k !== 2 + 3 * n || d_rdata !== ref_mem[idx[n]]) begin
          failures++; $display("FAIL b2b_ack%0d: at %0d data %h expected %0d %h", n, k, d_rdata, 2 + 3 * n, ref_mem[idx[n]]);
        end
        n++;
        if (n == 4) d_req = 1'b0;
        else d_addr = 32'(idx[n]) << 2;
      end
    end
    d_req = 1'b0;
    ref_last = 1'b1;
    checks++;
    if (n !== 4 || f_seen !== 1'b0) begin
      failures++; $display("FAIL b2b_count: %0d acks f_ack %b expected 4 0", n, f_seen);
    end
  endtask

  task automatic test_random();
    int fi, di, mode, fk, dk, rd_cnt, wr_cnt, exp_fk, exp_dk, exp_rd, exp_wr, t1;
    logic fe, de, we, fmis, dmis, first_d;
    logic [31:0] fa, da, wd;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      fe = (mode != 1); de = (mode != 0);
      fi = $urandom_range(0, 1023); di = $urandom_range(0, 1023);
      fa = 32'(fi) << 2; da = 32'(di) << 2;
      if ($urandom_range(0, 4) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) da[1:0] = 2'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1)); wd = $urandom;
      fmis = (fa[1:0] != 2'b00); dmis = (da[1:0] != 2'b00);
      // Reference: order from round-robin rule, latency 2 (aligned) or 1 (rejected), 1 idle cycle between.
      first_d = (fe && de) ? (ref_last == 1'b0) : de;
      exp_fk = 0; exp_dk = 0;
      if (first_d) begin
        exp_dk = dmis ? 1 : 2; t1 = exp_dk;
        if (fe) exp_fk = t1 + 1 + (fmis ? 1 : 2);
      end else begin
        exp_fk = fmis ? 1 : 2; t1 = exp_fk;
        if (de) exp_dk = t1 + 1 + (dmis ? 1 : 2);
      end
      exp_rd = ((fe && !fmis) ? 1 : 0) + ((de && !dmis && !we) ? 1 : 0);
      exp_wr = (de && !dmis && we) ? 1 : 0;
      f_addr = fa; d_addr = da; d_we = we; d_wdata = wd;
      f_req = fe; d_req = de;
      fk = 0; dk = 0; rd_cnt = 0; wr_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (f_ack && fk == 0) begin
          fk = k; f_req = 1'b0;
          checks++;
          if (f_err !== fmis || mem_addr !== fa || (!fmis && f_rdata !== ref_mem[fa[11:2]]) || d_rdata !== 32'h0) begin
            failures++; $display("FAIL rand%0d_f: err %b addr %h rdata %h expected %b %h %h", it, f_err, mem_addr, f_rdata, fmis, fa, ref_mem[fa[11:2]]);
          end
        end
        if (d_ack && dk == 0) begin
          dk = k; d_req = 1'b0;
          checks++;
          if (d_err !== dmis || mem_addr !== da || (!dmis && !we && d_rdata !== ref_mem[da[11:2]]) || f_rdata !== 32'h0) begin
            failures++; $display("FAIL rand%0d_d: err %b addr %h rdata %h expected %b %h %h", it, d_err, mem_addr, d_rdata, dmis, da, ref_mem[da[11:2]]);
          end
          if (!dmis && we) ref_mem[da[11:2]] = wd;
        end
      end
      f_req = 1'b0; d_req = 1'b0;
      if (fe && de) ref_last = ~first_d;
      else if (fe || de) ref_last = first_d;
      checks++;
      if (fk !== exp_fk || dk !== exp_dk || rd_cnt !== exp_rd || wr_cnt !== exp_wr || busy !== 1'b0) begin
        failures++; $display("FAIL rand%0d_timing: f@%0d d@%0d rd %0d wr %0d busy %b expected %0d %0d %0d %0d 0",
                             it, fk, dk, rd_cnt, wr_cnt, busy, exp_fk, exp_dk, exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      failures++; $display("FAIL protocol_exclusive: %0d violations expected 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    ref_last = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_conflict();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
